// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op classification shared by alu_muldiv
package alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLT, OP_SLTU,
      OP_SRL, OP_SRA, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_DIV, OP_REM
   } alu_op_e;
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;
   function automatic logic is_iterative(input alu_op_e op);
      return op >= OP_MUL;
   endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU ops 0-9; iterative codes yield zero
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   localparam int SHW = $clog2(WIDTH);
   logic [SHW-1:0] sh;
   logic [WIDTH-1:0] sra;
   assign sh = b[SHW-1:0];
   // kept apart so the unsigned select chain cannot turn it into a logical shift
   assign sra = $signed(a) >>> sh;
   always_comb
      y = op == OP_ADD  ? a + b :
          op == OP_SUB  ? a - b :
          op == OP_AND  ? a & b :
          op == OP_OR   ? a | b :
          op == OP_XOR  ? a ^ b :
          op == OP_SLL  ? a << sh :
          op == OP_SLT  ? WIDTH'($signed(a) < $signed(b)) :
          op == OP_SLTU ? WIDTH'(a < b) :
          op == OP_SRL  ? a >> sh :
          op == OP_SRA  ? sra : '0;
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: WIDTH-bit ALU, 1-cycle ops plus iterative radix-2 mul/div behind start/busy/done
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);
   localparam int SHW = $clog2(WIDTH);
   state_e state, state_n;
   alu_op_e op, op_q;
   logic [SHW-1:0] cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0] opb, comb_y, q, r, raw, fin_y;
   logic [WIDTH:0] mul_sum, div_sh, div_diff;
   logic sa, sb, sgn, neg;
   assign op = alu_op_e'(alu_ctrl);
   assign sgn = op == OP_DIV || op == OP_REM;
   assign busy = state != IDLE;
   assign zero = result == '0;
   // acc is {hi, lo}: product in MUL, {remainder, quotient/dividend} in DIV
   assign q = acc[WIDTH-1:0];
   assign r = acc[2*WIDTH-1:WIDTH];
   assign mul_sum = {1'b0, r} + (acc[0] ? {1'b0, opb} : '0);
   assign div_sh = acc[2*WIDTH-1:WIDTH-1];
   assign div_diff = div_sh - {1'b0, opb};
   // odd codes pick the high half; a zero divisor leaves the quotient unsigned
   assign raw = op_q[0] ? r : q;
   assign neg = op_q[0] ? sa : (sa ^ sb) && opb != '0;
   assign fin_y = neg ? -raw : raw;
   alu_comb #(.WIDTH(WIDTH)) u_comb (.op(op), .a(a), .b(b), .y(comb_y));
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = IDLE;
      case (state)
         IDLE:     state_n = start && is_iterative(op) ? (op >= OP_DIVU ? DIV : MUL) : IDLE;
         MUL, DIV: state_n = cnt == SHW'(WIDTH - 1) ? FIN : state;
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         result <= '0;
         done <= 1'b0;
         acc <= '0;
         opb <= '0;
         op_q <= OP_ADD;
         cnt <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (!is_iterative(op)) begin
                  result <= comb_y;
                  done <= 1'b1;
               end else begin
                  op_q <= op;
                  cnt <= '0;
                  sa <= sgn & a[WIDTH-1];
                  sb <= sgn & b[WIDTH-1];
                  acc <= {{WIDTH{1'b0}}, sgn & a[WIDTH-1] ? -a : a};
                  opb <= sgn & b[WIDTH-1] ? -b : b;
               end
            end
            MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
            DIV: begin
               acc <= {div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0], q[WIDTH-2:0], ~div_diff[WIDTH]};
               cnt <= cnt + 1'b1;
            end
            FIN: begin
               result <= fin_y;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
endmodule
